// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one simram-style memory (independent write port, read port with
//   one cycle of latency) between two requesters. Every cycle it decides who
//   is granted, issues the winning command(s) to the memory and returns read
//   data with a valid strobe for each port.
//
// Parameters
//   AW          address width
//   DW          data width
//   RR          1 = round-robin on conflicts, 0 = fixed priority (port 0 wins)
//   STARVE_MAX  fixed priority only: after this many consecutive lost
//               conflicts, port 1 wins once
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   req0/1, we0/1         request valid (held until granted); 1 = write
//   addr0/1, wdata0/1     command fields of each requester
//   gnt0/1                combinational: command accepted and issued this cycle
//   rvalid0/1             registered: rdata belongs to this port's read
//   rdata                 read data, a copy of mem_rdata shared by both ports
//   mem_we/waddr/wdata    memory write port
//   mem_re/raddr          memory read port
//   mem_rdata             memory read data, valid the cycle after mem_re
module ram_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int RR         = 1,
    parameter int STARVE_MAX = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_re,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata
);

    localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic          r_last;      // 1 = port 1 won the previous conflict
    logic [SW-1:0] r_starve;    // consecutive conflicts lost by port 1
    logic          r_rvalid0;
    logic          r_rvalid1;

    logic w_both;
    logic w_dual;
    logic w_conflict;
    logic w_win1;
    logic w_any;
    logic w_wr0;
    logic w_wr1;
    logic w_rd0;
    logic w_rd1;

    // A read and a write to different addresses use separate memory ports
    // and can both go out in the same cycle. A read and a write to the same
    // address are serialised, so the read never sees a half-updated word.
    assign w_both     = req0 & req1;
    assign w_dual     = w_both & (we0 ^ we1) & (addr0 != addr1);
    assign w_conflict = w_both & ~w_dual;
    assign w_any      = req0 | req1;

    // Choose the conflict winner: alternate in round-robin mode, otherwise
    // port 0 unless port 1 has already been starved for the limit.
    always_comb begin
        w_win1 = 1'b0;
        if (RR != 0) begin
            w_win1 = ~r_last;
        end else begin
            w_win1 = (r_starve == STARVE_LIM);
        end
    end

    // Grant generation: a lone requester is served the same cycle, and a
    // conflict is resolved by the winner selection above.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (w_conflict) begin
            gnt0 = ~w_win1;
            gnt1 = w_win1;
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

    assign w_wr0 = gnt0 & we0;
    assign w_wr1 = gnt1 & we1;
    assign w_rd0 = gnt0 & ~we0;
    assign w_rd1 = gnt1 & ~we1;

    // Steer granted commands onto the memory ports. A field that no granted
    // command uses carries port 0's value, or zero when nobody is requesting.
    always_comb begin
        mem_we    = w_wr0 | w_wr1;
        mem_re    = w_rd0 | w_rd1;
        mem_waddr = {AW{1'b0}};
        mem_wdata = {DW{1'b0}};
        mem_raddr = {AW{1'b0}};
        if (w_wr1) begin
            mem_waddr = addr1;
            mem_wdata = wdata1;
        end else if (w_any) begin
            mem_waddr = addr0;
            mem_wdata = wdata0;
        end else begin
            mem_waddr = {AW{1'b0}};
            mem_wdata = {DW{1'b0}};
        end
        if (w_rd1) begin
            mem_raddr = addr1;
        end else if (w_any) begin
            mem_raddr = addr0;
        end else begin
            mem_raddr = {AW{1'b0}};
        end
    end

    // Fairness state and read-return strobes. Reset clears the strobes at
    // once, so a read in flight during reset is dropped rather than returned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last    <= 1'b1;
            r_starve  <= {SW{1'b0}};
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= w_rd0;
            r_rvalid1 <= w_rd1;
            if (w_conflict) begin
                r_last <= w_win1;
            end
            if (RR == 0) begin
                // Dual issue leaves the counter untouched. It saturates at the
                // limit instead of wrapping.
                if (gnt1 && !w_dual) begin
                    r_starve <= {SW{1'b0}};
                end else if (w_conflict && (r_starve != STARVE_LIM)) begin
                    r_starve <= r_starve + SW'(1);
                end
            end
        end
    end

    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign rdata   = mem_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
`timescale 1ns/1ps
module tb_ram_arbiter;

    // Instance 0: fixed priority (RR=0). Instance 1: round-robin (RR=1).
    logic        clk = 1'b0;
    logic        reset_s;
    logic        mem_clr_s;
    logic        req0_s [2];
    logic        req1_s [2];
    logic        we0_s [2];
    logic        we1_s [2];
    logic [15:0] addr0_s [2];
    logic [15:0] addr1_s [2];
    logic [15:0] wdata0_s [2];
    logic [15:0] wdata1_s [2];
    logic        gnt0_s [2];
    logic        gnt1_s [2];
    logic        rvalid0_s [2];
    logic        rvalid1_s [2];
    logic [15:0] rdata_s [2];
    logic        mem_we_s [2];
    logic        mem_re_s [2];
    logic [15:0] mem_waddr_s [2];
    logic [15:0] mem_wdata_s [2];
    logic [15:0] mem_raddr_s [2];
    logic [15:0] mem_rdata_r [2];

    logic [15:0] mem_arr [2][256];
    logic        mem_vld [2][256];
    logic [15:0] ref_arr [2][256];
    logic        ref_vld [2][256];

    logic [15:0] sb00_q [$];
    logic [15:0] sb01_q [$];
    logic [15:0] sb10_q [$];
    logic [15:0] sb11_q [$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.AW(16), .DW(16), .RR(0), .STARVE_MAX(7)) u_fp (
        .clk(clk), .reset(reset_s),
        .req0(req0_s[0]), .req1(req1_s[0]), .we0(we0_s[0]), .we1(we1_s[0]),
        .addr0(addr0_s[0]), .addr1(addr1_s[0]), .wdata0(wdata0_s[0]), .wdata1(wdata1_s[0]),
        .gnt0(gnt0_s[0]), .gnt1(gnt1_s[0]), .rvalid0(rvalid0_s[0]), .rvalid1(rvalid1_s[0]),
        .rdata(rdata_s[0]), .mem_we(mem_we_s[0]), .mem_waddr(mem_waddr_s[0]),
        .mem_wdata(mem_wdata_s[0]), .mem_re(mem_re_s[0]), .mem_raddr(mem_raddr_s[0]),
        .mem_rdata(mem_rdata_r[0])
    );

    ram_arbiter #(.AW(16), .DW(16), .RR(1), .STARVE_MAX(7)) u_rr (
        .clk(clk), .reset(reset_s),
        .req0(req0_s[1]), .req1(req1_s[1]), .we0(we0_s[1]), .we1(we1_s[1]),
        .addr0(addr0_s[1]), .addr1(addr1_s[1]), .wdata0(wdata0_s[1]), .wdata1(wdata1_s[1]),
        .gnt0(gnt0_s[1]), .gnt1(gnt1_s[1]), .rvalid0(rvalid0_s[1]), .rvalid1(rvalid1_s[1]),
        .rdata(rdata_s[1]), .mem_we(mem_we_s[1]), .mem_waddr(mem_waddr_s[1]),
        .mem_wdata(mem_wdata_s[1]), .mem_re(mem_re_s[1]), .mem_raddr(mem_raddr_s[1]),
        .mem_rdata(mem_rdata_r[1])
    );

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return {a[7:0], ~a[7:0]};
    endfunction

    // simram model per instance: unwritten words read back as init_val(addr)
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_clr_s) begin
                for (int a = 0; a < 256; a++) mem_vld[k][a] <= 1'b0;
            end else begin
                if (mem_we_s[k]) begin
                    mem_arr[k][mem_waddr_s[k][7:0]] <= mem_wdata_s[k];
                    mem_vld[k][mem_waddr_s[k][7:0]] <= 1'b1;
                end
                if (mem_re_s[k]) begin
                    mem_rdata_r[k] <= mem_vld[k][mem_raddr_s[k][7:0]] ?
                                      mem_arr[k][mem_raddr_s[k][7:0]] : init_val(mem_raddr_s[k]);
                end
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_rd(input int k, input logic [15:0] a);
        return ref_vld[k][a[7:0]] ? ref_arr[k][a[7:0]] : init_val(a);
    endfunction

    task automatic ref_write(input int k, input logic [15:0] a, input logic [15:0] d);
        ref_arr[k][a[7:0]] = d;
        ref_vld[k][a[7:0]] = 1'b1;
    endtask

    task automatic sb_push(input int k, input int p, input logic [15:0] v);
        case ({k[0], p[0]})
            2'b00:   sb00_q.push_back(v);
            2'b01:   sb01_q.push_back(v);
            2'b10:   sb10_q.push_back(v);
            default: sb11_q.push_back(v);
        endcase
    endtask

    task automatic sb_check(input int k, input int p, input logic rv, input logic [15:0] rd);
        int          sz;
        logic [15:0] e;
        if (rv) begin
            case ({k[0], p[0]})
                2'b00:   sz = sb00_q.size();
                2'b01:   sz = sb01_q.size();
                2'b10:   sz = sb10_q.size();
                default: sz = sb11_q.size();
            endcase
            if (sz == 0) begin
                check_val($sformatf("unexp_rvalid k%0d p%0d", k, p), 32'(rv), 32'(1'b0));
            end else begin
                case ({k[0], p[0]})
                    2'b00:   e = sb00_q.pop_front();
                    2'b01:   e = sb01_q.pop_front();
                    2'b10:   e = sb10_q.pop_front();
                    default: e = sb11_q.pop_front();
                endcase
                check_val($sformatf("rdata k%0d p%0d", k, p), 32'(rd), 32'(e));
            end
        end
    endtask

    // Read-return monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (!reset_s) begin
            for (int k = 0; k < 2; k++) begin
                sb_check(k, 0, rvalid0_s[k], rdata_s[k]);
                sb_check(k, 1, rvalid1_s[k], rdata_s[k]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int k, input int p, input logic r, input logic w,
                            input logic [15:0] a, input logic [15:0] d);
        if (p == 0) begin
            req0_s[k] = r; we0_s[k] = w; addr0_s[k] = a; wdata0_s[k] = d;
        end else begin
            req1_s[k] = r; we1_s[k] = w; addr1_s[k] = a; wdata1_s[k] = d;
        end
    endtask

    task automatic idle_all();
        for (int k = 0; k < 2; k++) begin
            set_port(k, 0, 1'b0, 1'b0, 16'h0000, 16'h0000);
            set_port(k, 1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        end
    endtask

    task automatic chk_gnt(input string tag, input int k, input logic e0, input logic e1);
        check_val($sformatf("%s k%0d gnt0", tag, k), 32'(gnt0_s[k]), 32'(e0));
        check_val($sformatf("%s k%0d gnt1", tag, k), 32'(gnt1_s[k]), 32'(e1));
    endtask

    task automatic chk_rv(input string tag, input int k, input logic e0, input logic e1);
        check_val($sformatf("%s k%0d rvalid0", tag, k), 32'(rvalid0_s[k]), 32'(e0));
        check_val($sformatf("%s k%0d rvalid1", tag, k), 32'(rvalid1_s[k]), 32'(e1));
    endtask

    // Both ports read on every cycle; each grant is followed by a fresh read
    task automatic run_dual_reads(input int k, input int n, input bit rr);
        logic pe0 = 1'b0;
        logic pe1 = 1'b0;
        logic e1;
        for (int i = 0; i < n; i++) begin
            step();
            set_port(k, 0, 1'b1, 1'b0, 16'h0050, 16'h0000);
            set_port(k, 1, 1'b1, 1'b0, 16'h0060, 16'h0000);
            #1;
            e1 = rr ? (i % 2 == 1) : (i % 8 == 7);
            chk_rv($sformatf("dual_rd c%0d", i), k, pe0, pe1);
            chk_gnt($sformatf("dual_rd c%0d", i), k, ~e1, e1);
            if (e1) sb_push(k, 1, exp_rd(k, 16'h0060));
            else    sb_push(k, 0, exp_rd(k, 16'h0050));
            pe0 = ~e1;
            pe1 = e1;
        end
        step();
        idle_all();
        #1;
        chk_rv("dual_rd tail", k, pe0, pe1);
    endtask

    initial begin
        reset_s   = 1'b1;
        mem_clr_s = 1'b1;
        idle_all();
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 256; a++) ref_vld[k][a] = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        // Reset state with no requests
        for (int k = 0; k < 2; k++) begin
            chk_gnt("reset", k, 1'b0, 1'b0);
            chk_rv("reset", k, 1'b0, 1'b0);
            check_val($sformatf("reset k%0d mem_we", k), 32'(mem_we_s[k]), 32'(1'b0));
            check_val($sformatf("reset k%0d mem_re", k), 32'(mem_re_s[k]), 32'(1'b0));
        end
        step();
        reset_s   = 1'b0;
        mem_clr_s = 1'b0;

        // 1: lone read on port 0
        step();
        for (int k = 0; k < 2; k++) set_port(k, 0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk_gnt("t1", k, 1'b1, 1'b0);
            check_val($sformatf("t1 k%0d mem_re", k), 32'(mem_re_s[k]), 32'(1'b1));
            check_val($sformatf("t1 k%0d mem_we", k), 32'(mem_we_s[k]), 32'(1'b0));
            check_val($sformatf("t1 k%0d raddr", k), 32'(mem_raddr_s[k]), 32'(16'h0010));
            sb_push(k, 0, exp_rd(k, 16'h0010));
        end
        step();
        idle_all();
        #1;
        for (int k = 0; k < 2; k++) chk_rv("t1", k, 1'b1, 1'b0);

        // 2: dual issue, write on port 0 and read on port 1
        step();
        for (int k = 0; k < 2; k++) begin
            set_port(k, 0, 1'b1, 1'b1, 16'h0020, 16'h1234);
            set_port(k, 1, 1'b1, 1'b0, 16'h0030, 16'h0000);
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            chk_gnt("t2", k, 1'b1, 1'b1);
            check_val($sformatf("t2 k%0d mem_we", k), 32'(mem_we_s[k]), 32'(1'b1));
            check_val($sformatf("t2 k%0d mem_re", k), 32'(mem_re_s[k]), 32'(1'b1));
            check_val($sformatf("t2 k%0d waddr", k), 32'(mem_waddr_s[k]), 32'(16'h0020));
            check_val($sformatf("t2 k%0d wdata", k), 32'(mem_wdata_s[k]), 32'(16'h1234));
            check_val($sformatf("t2 k%0d raddr", k), 32'(mem_raddr_s[k]), 32'(16'h0030));
            ref_write(k, 16'h0020, 16'h1234);
            sb_push(k, 1, exp_rd(k, 16'h0030));
        end
        step();
        idle_all();
        for (int k = 0; k < 2; k++) set_port(k, 1, 1'b1, 1'b0, 16'h0020, 16'h0000);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk_rv("t2", k, 1'b0, 1'b1);
            chk_gnt("t2 readback", k, 1'b0, 1'b1);
            sb_push(k, 1, exp_rd(k, 16'h0020));
        end
        step();
        idle_all();
        #1;
        for (int k = 0; k < 2; k++) chk_rv("t2 readback", k, 1'b0, 1'b1);

        // 3: round-robin alternation; 5: fixed priority with starvation relief
        run_dual_reads(1, 6, 1'b1);
        run_dual_reads(0, 16, 1'b0);

        // 4: same-address write/read conflict, write first, read sees new data
        step();
        for (int k = 0; k < 2; k++) begin
            set_port(k, 0, 1'b1, 1'b1, 16'h0040, 16'hBEEF);
            set_port(k, 1, 1'b1, 1'b0, 16'h0040, 16'h0000);
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            chk_gnt("t4 a", k, 1'b1, 1'b0);
            check_val($sformatf("t4 k%0d mem_we", k), 32'(mem_we_s[k]), 32'(1'b1));
            check_val($sformatf("t4 k%0d mem_re", k), 32'(mem_re_s[k]), 32'(1'b0));
            ref_write(k, 16'h0040, 16'hBEEF);
        end
        step();
        for (int k = 0; k < 2; k++) set_port(k, 0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk_gnt("t4 b", k, 1'b0, 1'b1);
            check_val($sformatf("t4 k%0d raddr", k), 32'(mem_raddr_s[k]), 32'(16'h0040));
            sb_push(k, 1, exp_rd(k, 16'h0040));
        end
        step();
        idle_all();
        #1;
        for (int k = 0; k < 2; k++) chk_rv("t4", k, 1'b0, 1'b1);

        // 6: reset while a read is returning; then first conflict goes to port 0
        step();
        for (int k = 0; k < 2; k++) set_port(k, 0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        #1;
        for (int k = 0; k < 2; k++) chk_gnt("t6 pre", k, 1'b1, 1'b0);
        step();
        idle_all();
        #1;
        for (int k = 0; k < 2; k++) chk_rv("t6 pending", k, 1'b1, 1'b0);
        reset_s = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) chk_rv("t6 in_reset", k, 1'b0, 1'b0);
        step();
        step();
        reset_s = 1'b0;
        step();
        for (int k = 0; k < 2; k++) begin
            set_port(k, 0, 1'b1, 1'b0, 16'h0070, 16'h0000);
            set_port(k, 1, 1'b1, 1'b0, 16'h0080, 16'h0000);
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            chk_gnt("t6 post", k, 1'b1, 1'b0);
            sb_push(k, 0, exp_rd(k, 16'h0070));
        end
        step();
        for (int k = 0; k < 2; k++) set_port(k, 0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk_gnt("t6 second", k, 1'b0, 1'b1);
            sb_push(k, 1, exp_rd(k, 16'h0080));
        end
        step();
        idle_all();
        repeat (3) step();
        check_val("sb_drain", 32'(sb00_q.size() + sb01_q.size() + sb10_q.size() + sb11_q.size()),
                  32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
